// File: rtl/mac_guffin.sv
// rtl/mac_guffin.sv - Iterative MacGuffin encryptor, one round per clock, with an on-chip key schedule
// The key schedule runs the same round datapath for 2048 cycles after every reset release.
module mac_guffin (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    input  logic [63:0]  s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    output logic [63:0]  m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready
);
    typedef enum logic [1:0] {S_KEYGEN, S_IDLE, S_ROUND, S_DONE} state_t;

    // DES S-boxes, rows 0..3 of 16 entries each; entry 0 sits in the top nibble.
    localparam logic [255:0] SBOX1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] SBOX2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] SBOX3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] SBOX4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] SBOX5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] SBOX6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] SBOX7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] SBOX8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    // Row from the outer bits, column from the middle four; only the low two output bits are kept.
    function automatic logic [1:0] sbox_out(input logic [255:0] tbl, input logic [5:0] s);
        logic [5:0] idx;
        logic [3:0] d;
        idx = {s[5], s[0], s[4:1]};
        d   = tbl[(63 - int'(idx)) * 4 +: 4];
        return d[1:0];
    endfunction

    state_t       state_q, state_d;
    logic [63:0]  blk_q, blk_d;
    logic [4:0]   rnd_q, rnd_d;
    logic [5:0]   kg_q, kg_d;
    logic [127:0] key_q;
    logic [15:0]  k_q [96];
    logic [63:0]  rnd_in, rnd_out;
    logic [15:0]  a, b, c, f;
    logic [6:0]   rk_base, wk_base;
    logic         last_round, kg_load, k_upd;

    assign last_round = (rnd_q == 5'd31);
    // First round of each schedule half starts from the key half instead of the running state.
    assign kg_load    = (state_q == S_KEYGEN) && (rnd_q == 5'd0) && (kg_q[4:0] == 5'd0);
    assign rnd_in     = kg_load ? (kg_q[5] ? key_q[63:0] : key_q[127:64]) : blk_q;

    assign rk_base = {2'b00, rnd_q} + {1'b0, rnd_q, 1'b0};
    assign wk_base = {2'b00, kg_q[4:0]} + {1'b0, kg_q[4:0], 1'b0};

    assign a = rnd_in[47:32] ^ k_q[rk_base];
    assign b = rnd_in[31:16] ^ k_q[rk_base + 7'd1];
    assign c = rnd_in[15:0]  ^ k_q[rk_base + 7'd2];

    assign f = {sbox_out(SBOX8, {c[9],  c[3],  b[4],  b[0],  a[13], a[11]}),
                sbox_out(SBOX7, {c[7],  c[2],  b[11], b[5],  a[15], a[9]}),
                sbox_out(SBOX6, {c[5],  c[1],  b[15], b[12], a[8],  a[7]}),
                sbox_out(SBOX5, {c[12], c[6],  b[14], b[3],  a[10], a[0]}),
                sbox_out(SBOX4, {c[10], c[4],  b[2],  b[1],  a[14], a[12]}),
                sbox_out(SBOX3, {c[15], c[0],  b[13], b[8],  a[6],  a[3]}),
                sbox_out(SBOX2, {c[14], c[8],  b[10], b[7],  a[4],  a[1]}),
                sbox_out(SBOX1, {c[13], c[11], b[9],  b[6],  a[5],  a[2]})};

    assign rnd_out = {rnd_in[47:0], rnd_in[63:48] ^ f};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_KEYGEN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_KEYGEN: if (last_round && kg_q == 6'd63) state_d = S_IDLE;
            S_IDLE:   if (s_axis_tvalid) state_d = S_ROUND;
            S_ROUND:  if (last_round) state_d = S_DONE;
            S_DONE:   if (m_axis_tready) state_d = S_IDLE;
            default:  state_d = S_KEYGEN;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state_q)
            S_IDLE:  s_axis_tready = 1'b1;
            S_DONE:  m_axis_tvalid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        blk_d = blk_q;
        rnd_d = rnd_q;
        kg_d  = kg_q;
        k_upd = 1'b0;
        case (state_q)
            S_KEYGEN: begin
                blk_d = rnd_out;
                rnd_d = rnd_q + 5'd1;
                if (last_round) begin
                    k_upd = 1'b1;
                    kg_d  = kg_q + 6'd1;
                    // Do not leave schedule state visible on the output bus.
                    if (kg_q == 6'd63) blk_d = '0;
                end
            end
            S_IDLE: if (s_axis_tvalid) blk_d = s_axis_tdata;
            S_ROUND: begin
                blk_d = rnd_out;
                rnd_d = rnd_q + 5'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q <= '0;
            rnd_q <= '0;
            kg_q  <= '0;
            key_q <= key;
            for (int i = 0; i < 96; i++) k_q[i] <= '0;
        end else begin
            blk_q <= blk_d;
            rnd_q <= rnd_d;
            kg_q  <= kg_d;
            if (k_upd) begin
                k_q[wk_base]         <= k_q[wk_base]         ^ rnd_out[63:48];
                k_q[wk_base + 7'd1]  <= k_q[wk_base + 7'd1]  ^ rnd_out[47:32];
                k_q[wk_base + 7'd2]  <= k_q[wk_base + 7'd2]  ^ rnd_out[31:16];
            end
        end
    end

    assign m_axis_tdata = blk_q;

endmodule

// File: tb/tb_mac_guffin.sv
// tb/tb_mac_guffin.sv - Self-checking bench for mac_guffin against a behavioural MacGuffin model
module tb_mac_guffin;
    logic         clk;
    logic         rst;
    logic [127:0] key;
    logic [63:0]  s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [63:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;

    mac_guffin dut (
        .clk(clk), .rst(rst), .key(key),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DES S-box b, row r stored at index 4*b + r; column 0 is the top nibble.
    logic [63:0] des_row [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    // Input bit k of S-box j: bits 0,1 from a, 2,3 from b, 4,5 from c.
    int sbits [8][6] = '{
        '{2, 5, 6, 9, 11, 13}, '{1, 4, 7, 10, 8, 14}, '{3, 6, 8, 13, 0, 15}, '{12, 14, 1, 2, 4, 10},
        '{0, 10, 3, 14, 6, 12}, '{7, 8, 12, 15, 1, 5}, '{9, 15, 5, 11, 2, 7}, '{11, 13, 0, 4, 3, 9}};

    logic [15:0] mk [96];

    function automatic logic [15:0] model_f(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        logic [15:0] w [3];
        logic [15:0] f;
        logic [63:0] r;
        int s, row, col;
        w[0] = a; w[1] = b; w[2] = c;
        f = '0;
        for (int j = 0; j < 8; j++) begin
            s = 0;
            for (int k = 0; k < 6; k++)
                if (w[k / 2][sbits[j][k]]) s = s | (1 << k);
            row = ((s >> 4) & 2) | (s & 1);
            col = (s >> 1) & 15;
            r = des_row[4 * j + row];
            f = f | (16'((r >> (4 * (15 - col))) & 64'd3) << (2 * j));
        end
        return f;
    endfunction

    function automatic logic [63:0] model_encrypt(input logic [63:0] p);
        logic [15:0] r [4];
        logic [15:0] t;
        r[0] = p[63:48]; r[1] = p[47:32]; r[2] = p[31:16]; r[3] = p[15:0];
        for (int i = 0; i < 32; i++) begin
            t = r[0] ^ model_f(r[1] ^ mk[3 * i], r[2] ^ mk[3 * i + 1], r[3] ^ mk[3 * i + 2]);
            r[0] = r[1]; r[1] = r[2]; r[2] = r[3]; r[3] = t;
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    task automatic model_keysched(input logic [127:0] k);
        logic [63:0] st;
        for (int i = 0; i < 96; i++) mk[i] = '0;
        for (int h = 0; h < 2; h++) begin
            st = (h == 0) ? k[127:64] : k[63:0];
            for (int j = 0; j < 32; j++) begin
                st = model_encrypt(st);
                mk[3 * j]     = mk[3 * j]     ^ st[63:48];
                mk[3 * j + 1] = mk[3 * j + 1] ^ st[47:32];
                mk[3 * j + 2] = mk[3 * j + 2] ^ st[31:16];
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts cycles from reset release until s_axis_tready rises; optionally changes key mid-schedule.
    task automatic run_keygen(input bit poke, input logic [127:0] poke_key, output int cnt, output int vbad);
        cnt = 0;
        vbad = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
            if (m_axis_tvalid !== 1'b0) vbad++;
            if (poke && cnt == 5) key = poke_key;
        end while (s_axis_tready !== 1'b1 && cnt < 3000);
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (s_axis_tready !== 1'b1 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
    endtask

    task automatic encrypt_one(input logic [63:0] pt, output logic [63:0] ct, output int lat);
        wait_ready();
        s_axis_tdata  = pt;
        s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 64'hDEAD_BEEF_0BAD_F00D;
        lat = 0;
        while (m_axis_tvalid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        ct = m_axis_tdata;
    endtask

    typedef struct {
        logic [63:0] pt;
        logic [63:0] exp_ct;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [6];
    logic [63:0] b2b  [4];
    logic [63:0] ct;
    int          lat, cnt, vbad, bad;

    initial begin
        rst = 1'b1; key = '0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_s_tready", 64'(s_axis_tready), 64'd0);
        check("reset_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("reset_m_tdata", m_axis_tdata, 64'd0);

        rst = 1'b0;
        run_keygen(1'b0, '0, cnt, vbad);
        check("keygen_cycles", 64'(cnt), 64'd2048);
        check("keygen_no_tvalid", 64'(vbad), 64'd0);
        check("idle_tdata_cleared", m_axis_tdata, 64'd0);

        model_keysched(128'd0);
        vecs[0].pt = 64'h0000000000000000;
        vecs[1].pt = 64'hFFFFFFFFFFFFFFFF;
        vecs[2].pt = 64'h0123456789ABCDEF;
        vecs[3].pt = 64'hFEDCBA9876543210;
        vecs[4].pt = 64'h0000000000000001;
        vecs[5].pt = 64'h8000000000000000;
        foreach (vecs[i]) begin
            vecs[i].exp_ct  = model_encrypt(vecs[i].pt);
            vecs[i].exp_lat = 32;
        end

        for (int i = 0; i < 6; i++) begin
            encrypt_one(vecs[i].pt, ct, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_ct", i), ct, vecs[i].exp_ct);
            @(posedge clk); #1;
        end

        // Back-to-back with s_axis_tvalid held high; next block presented as soon as the previous is taken.
        b2b[0] = 64'h0; b2b[1] = 64'hFFFFFFFFFFFFFFFF; b2b[2] = 64'h0123456789ABCDEF; b2b[3] = 64'hFEDCBA9876543210;
        s_axis_tdata  = b2b[0];
        s_axis_tvalid = 1'b1;
        wait_ready();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) s_axis_tdata = b2b[i + 1];
            else s_axis_tvalid = 1'b0;
            lat = 0;
            while (m_axis_tvalid !== 1'b1 && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("b2b%0d_latency", i), 64'(lat), 64'd32);
            check($sformatf("b2b%0d_ct", i), m_axis_tdata, model_encrypt(b2b[i]));
            @(posedge clk); #1;
            check($sformatf("b2b%0d_ready_after", i), 64'(s_axis_tready), 64'd1);
        end

        // Output backpressure for 100 cycles.
        m_axis_tready = 1'b0;
        encrypt_one(64'h0123456789ABCDEF, ct, lat);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (m_axis_tdata !== model_encrypt(64'h0123456789ABCDEF) || m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0)
                bad++;
        end
        check("bp_hold_violations", 64'(bad), 64'd0);
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        check("bp_tvalid_drop", 64'(m_axis_tvalid), 64'd0);
        check("bp_s_tready", 64'(s_axis_tready), 64'd1);

        // Reset after round 10 of a block, with a new key; the pin changes again mid-schedule.
        wait_ready();
        s_axis_tdata  = 64'hFEDCBA9876543210;
        s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        vbad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (m_axis_tvalid !== 1'b0) vbad++;
        end
        key = 128'h000102030405060708090A0B0C0D0E0F;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tdata !== 64'd0) vbad++;
        rst = 1'b0;
        run_keygen(1'b1, 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0, cnt, bad);
        check("abort_no_output", 64'(vbad + bad), 64'd0);
        check("rekey_cycles", 64'(cnt), 64'd2048);
        model_keysched(128'h000102030405060708090A0B0C0D0E0F);
        encrypt_one(64'h0123456789ABCDEF, ct, lat);
        check("rekey_latency", 64'(lat), 64'd32);
        check("rekey_ct", ct, model_encrypt(64'h0123456789ABCDEF));
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
